// File: rtl/frame_buf_ctrl.sv
// Raster timing and ping-pong buffer controller for the display frame mux.
// Scans a raster, drives a one-hot buf0/blank/buf1 select with a registered
// read address into the front buffer, and swaps front/back buffers only at
// a frame boundary once the writer has reported the back buffer complete.
module frame_buf_ctrl #(
   parameter  int H_ACTIVE = 640,
   parameter  int H_BLANK  = 160,
   parameter  int V_ACTIVE = 480,
   parameter  int V_BLANK  = 45,
   parameter  int ADDR_W   = 19,
   localparam int H_TOTAL  = H_ACTIVE + H_BLANK,
   localparam int V_TOTAL  = V_ACTIVE + V_BLANK,
   localparam int HW       = $clog2(H_TOTAL),
   localparam int VW       = $clog2(V_TOTAL)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              wr_done,
   output logic              sel_buf0,
   output logic              sel_blank,
   output logic              sel_buf1,
   output logic              pixel_valid,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              frame_start,
   output logic              swap_ack,
   output logic              back_buf,
   output logic [HW-1:0]     hcount,
   output logic [VW-1:0]     vcount
);

   logic h_last;
   logic v_last;
   logic at_origin;
   logic active;
   logic swap;
   logic pending;
   logic swap_done;

   assign h_last    = (hcount == HW'(H_TOTAL - 1));
   assign v_last    = (vcount == VW'(V_TOTAL - 1));
   assign at_origin = (hcount == '0) && (vcount == '0);
   assign active    = (hcount < HW'(H_ACTIVE)) && (vcount < VW'(V_ACTIVE));
   // A completed back buffer is taken at the last pixel of the frame, either
   // from an earlier report or from one arriving in that very cycle.
   assign swap      = en && h_last && v_last && (pending || wr_done);

   // Raster counters; disabling parks the scan at the origin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount <= '0;
         vcount <= '0;
      end else if (!en) begin
         hcount <= '0;
         vcount <= '0;
      end else if (h_last) begin
         hcount <= '0;
         vcount <= v_last ? '0 : vcount + VW'(1);
      end else begin
         hcount <= hcount + HW'(1);
      end
   end

   // Swap handshake; front buffer is always the complement of back_buf.
   // pending and back_buf deliberately survive en=0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         back_buf  <= 1'b1;
         pending   <= 1'b0;
         swap_done <= 1'b0;
      end else begin
         swap_done <= swap;
         if (swap) begin
            back_buf <= ~back_buf;
            pending  <= 1'b0;
         end else if (wr_done) begin
            pending  <= 1'b1;
         end
      end
   end

   // Registered pixel outputs describing the previous cycle's raster position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_buf0    <= 1'b0;
         sel_blank   <= 1'b1;
         sel_buf1    <= 1'b0;
         pixel_valid <= 1'b0;
         rd_addr     <= '0;
         frame_start <= 1'b0;
         swap_ack    <= 1'b0;
      end else if (!en) begin
         sel_buf0    <= 1'b0;
         sel_blank   <= 1'b1;
         sel_buf1    <= 1'b0;
         pixel_valid <= 1'b0;
         rd_addr     <= '0;
         frame_start <= 1'b0;
         swap_ack    <= 1'b0;
      end else begin
         sel_buf0    <= active && back_buf;
         sel_buf1    <= active && !back_buf;
         sel_blank   <= !active;
         pixel_valid <= active;
         frame_start <= at_origin;
         swap_ack    <= at_origin && swap_done;
         // Running address: restarts at the origin pixel, holds through blank.
         if (active) begin
            rd_addr <= at_origin ? '0 : rd_addr + ADDR_W'(1);
         end
      end
   end

endmodule
